// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator keypad/operand path.
package calc_pkg;
   localparam int DIGIT_W   = 4;
   localparam int DIGIT_MAX = 9;
   typedef enum logic [1:0] {IDLE, ENTRY, HOLD} state_t;
endpackage

// File: rtl/digit_entry_ctrl_key_edge_det.sv
// key_edge_det: registers one key level and emits a one-cycle press pulse on its rising edge.
// Optional input debouncer enabled by DIGIT_ENTRY_DEBOUNCE_EN.
module key_edge_det #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_key,
   output logic o_press
);
   logic r_cur, r_prev, w_level;
   if (DEBOUNCE_CYCLES < 1) begin : g_chk
      $error("DEBOUNCE_CYCLES must be at least 1");
   end
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [CW-1:0] r_cnt;
   logic          r_filt;
   // filtered level follows the raw level only after DEBOUNCE_CYCLES stable samples
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_cnt  <= '0;
         r_filt <= 1'b0;
      end else if (r_cur == r_filt) r_cnt <= '0;
      else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
         r_filt <= r_cur;
         r_cnt  <= '0;
      end else r_cnt <= r_cnt + 1'b1;
   assign w_level = r_filt;
`else
   assign w_level = r_cur;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_cur  <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_cur  <= i_key;
         r_prev <= w_level;
      end
   assign o_press = w_level & ~r_prev;
endmodule

// File: rtl/digit_entry_ctrl.sv
// digit_entry_ctrl: keypad decimal operand accumulator with valid/ready hand-off.
// Define DIGIT_ENTRY_DEBOUNCE_EN to debounce the key levels before edge detection.
module digit_entry_ctrl
   import calc_pkg::*;
#(
   parameter int MAX_DIGITS      = 4,
   parameter int VAL_W           = 14,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DIGIT_W-1:0]               key_digit,
   input  logic                             key_any,
   input  logic                             key_clr,
   input  logic                             key_enter,
   output logic [VAL_W-1:0]                 operand,
   output logic                             operand_valid,
   input  logic                             operand_ready,
   output logic [$clog2(MAX_DIGITS+1)-1:0]  digit_cnt,
   output logic                             err
);
   localparam int CW = $clog2(MAX_DIGITS + 1);
   if (10 ** MAX_DIGITS - 1 >= 2 ** VAL_W) begin : g_chk
      $error("VAL_W too narrow for MAX_DIGITS");
   end
   state_t             r_state;
   logic [VAL_W-1:0]   r_op;
   logic [CW-1:0]      r_cnt;
   logic               r_err;
   logic               w_dig_p, w_clr_p, w_ent_p, w_bad, w_full;
   logic [VAL_W-1:0]   w_next;
   key_edge_det #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_any (.clk(clk), .rst(rst), .i_key(key_any),   .o_press(w_dig_p));
   key_edge_det #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (.clk(clk), .rst(rst), .i_key(key_clr),   .o_press(w_clr_p));
   key_edge_det #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ent (.clk(clk), .rst(rst), .i_key(key_enter), .o_press(w_ent_p));
   assign w_bad  = key_digit > DIGIT_W'(DIGIT_MAX);
   assign w_full = r_cnt == CW'(MAX_DIGITS);
   assign w_next = (r_op << 3) + (r_op << 1) + VAL_W'(key_digit);
   // priority clr > hold/transfer > enter > digit; enter also swallows a same-cycle digit
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= IDLE;
         r_op    <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else if (w_clr_p) begin
         r_state <= IDLE;
         r_op    <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else if (r_state == HOLD) begin
         if (operand_ready) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
         end
      end else if (w_ent_p) begin
         if (r_state == ENTRY) r_state <= HOLD;
      end else if (w_dig_p) begin
         if (w_bad || w_full) r_err <= 1'b1;
         else begin
            r_op    <= w_next;
            r_cnt   <= r_cnt + 1'b1;
            r_state <= ENTRY;
         end
      end
   assign operand       = r_op;
   assign operand_valid = r_state == HOLD;
   assign digit_cnt     = r_cnt;
   assign err           = r_err;
endmodule

// File: tb/tb_digit_entry_ctrl.sv
// tb_digit_entry_ctrl: directed stimulus with a transfer scoreboard for digit_entry_ctrl.
module tb_digit_entry_ctrl;
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
   localparam int DB = 4;
`else
   localparam int DB = 0;
`endif
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  key_digit;
   logic        key_any, key_clr, key_enter;
   logic [13:0] operand;
   logic        operand_valid, operand_ready;
   logic [2:0]  digit_cnt;
   logic        err;
   int          total = 0;
   int          passed = 0;
   int          q[$];
   logic        mon_hold = 1'b0;
   int          mon_op = 0;
   always #5 clk = ~clk;
   digit_entry_ctrl #(.MAX_DIGITS(4), .VAL_W(14), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .key_digit(key_digit), .key_any(key_any), .key_clr(key_clr),
      .key_enter(key_enter), .operand(operand), .operand_valid(operand_valid),
      .operand_ready(operand_ready), .digit_cnt(digit_cnt), .err(err)
   );
   function automatic void chk(string n, int a, int e);
      total++;
      if (a == e) passed++;
      else $display("FAIL %s: got %0d expected %0d", n, a, e);
   endfunction
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic press(input logic a, input logic c, input logic e, input logic [3:0] d);
      key_digit = d;
      key_any   = a;
      key_clr   = c;
      key_enter = e;
      tick(1 + DB);
      key_any   = 1'b0;
      key_clr   = 1'b0;
      key_enter = 1'b0;
      tick(2 + DB);
   endtask
   task automatic digit(input logic [3:0] d);
      press(1'b1, 1'b0, 1'b0, d);
   endtask
   task automatic state_chk(input string n, input int op, input int cnt, input int v, input int e);
      chk({n, "_operand"}, int'(operand), op);
      chk({n, "_cnt"}, int'(digit_cnt), cnt);
      chk({n, "_valid"}, int'(operand_valid), v);
      chk({n, "_err"}, int'(err), e);
   endtask
   // monitor: every accepted transfer must match the oldest expected operand
   always @(negedge clk) begin
      if (rst) mon_hold = 1'b0;
      else begin
         if (operand_valid && mon_hold) chk("hold_stable", int'(operand), mon_op);
         if (operand_valid && operand_ready) begin
            if (q.size() == 0) begin
               total++;
               $display("FAIL unexpected_xfer: got operand %0d expected no transfer", operand);
            end else chk("xfer", int'(operand), q.pop_front());
            mon_hold = 1'b0;
         end else begin
            mon_hold = operand_valid;
            mon_op   = int'(operand);
         end
      end
   end
   initial begin
      rst = 1'b1;
      key_digit = 4'd0;
      key_any = 1'b0;
      key_clr = 1'b0;
      key_enter = 1'b0;
      operand_ready = 1'b0;
      tick(2);
      state_chk("reset", 0, 0, 0, 0);
      rst = 1'b0;
      tick(1);
      operand_ready = 1'b1;
      digit(4'd1);
      digit(4'd2);
      digit(4'd3);
      state_chk("e123", 123, 3, 0, 0);
      q.push_back(123);
      press(1'b0, 1'b0, 1'b1, 4'd0);
      state_chk("after123", 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) digit(i == 4 ? 4'd5 : 4'd9);
      state_chk("ovf", 9999, 4, 0, 1);
      q.push_back(9999);
      press(1'b0, 1'b0, 1'b1, 4'd0);
      state_chk("after9999", 0, 0, 0, 1);
      press(1'b0, 1'b1, 1'b0, 4'd0);
      state_chk("clr_err", 0, 0, 0, 0);
      operand_ready = 1'b0;
      digit(4'd4);
      digit(4'd2);
      q.push_back(42);
      press(1'b0, 1'b0, 1'b1, 4'd0);
      state_chk("hold", 42, 2, 1, 0);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("hold_valid", int'(operand_valid), 1);
         chk("hold_op", int'(operand), 42);
      end
      digit(4'd5);
      state_chk("hold_digit", 42, 2, 1, 0);
      operand_ready = 1'b1;
      tick(1);
      state_chk("after42", 0, 0, 0, 0);
      key_digit = 4'd7;
      key_any = 1'b1;
      tick(20);
      key_any = 1'b0;
      tick(2 + 2 * DB);
      state_chk("held7", 7, 1, 0, 0);
      press(1'b0, 1'b1, 1'b0, 4'd0);
      digit(4'd5);
      press(1'b0, 1'b1, 1'b1, 4'd0);
      state_chk("clr_ent", 0, 0, 0, 0);
      digit(4'd1);
      digit(4'd2);
      q.push_back(12);
      press(1'b1, 1'b0, 1'b1, 4'd3);
      state_chk("dig_ent", 0, 0, 0, 0);
      press(1'b0, 1'b0, 1'b1, 4'd0);
      state_chk("idle_ent", 0, 0, 0, 0);
      digit(4'd8);
      digit(4'd12);
      state_chk("illegal", 8, 1, 0, 1);
      press(1'b0, 1'b1, 1'b0, 4'd0);
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
      key_digit = 4'd5;
      key_any = 1'b1;
      tick(2);
      key_any = 1'b0;
      tick(12);
      state_chk("glitch", 0, 0, 0, 0);
      digit(4'd5);
      state_chk("debounced", 5, 1, 0, 0);
      press(1'b0, 1'b1, 1'b0, 4'd0);
`endif
      digit(4'd3);
      digit(4'd4);
      state_chk("pre_rst", 34, 2, 0, 0);
      #2 rst = 1'b1;
      #1;
      state_chk("async_rst", 0, 0, 0, 0);
      tick(2);
      rst = 1'b0;
      tick(2);
      state_chk("post_rst", 0, 0, 0, 0);
      chk("queue_empty", q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/digit_entry_ctrl.md
Name: digit_entry_ctrl

Overview:
Keypad operand-entry controller for the calculator datapath.
- Consumes the 4-bit digit code produced by the dec_to_bin decoder plus an any-key strobe, clear key and enter key.
- Edge-detects each key press and accumulates a multi-digit decimal operand into a binary register (value*10 + digit).
- Hands the completed operand to the ALU/operand stage over a valid/ready handshake.

Parameters:
- MAX_DIGITS, 4, maximum digits accepted per operand.
- VAL_W, 14, operand width in bits; must satisfy 10^MAX_DIGITS - 1 < 2^VAL_W.
- DEBOUNCE_CYCLES, 4, stable cycles required per key level (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- key_digit  in  4  digit code from dec_to_bin.
- key_any  in  1  OR of the ten digit key lines; high while any digit key is held.
- key_clr  in  1  clear key level.
- key_enter  in  1  enter key level.
- operand  out  VAL_W  accumulated operand value.
- operand_valid  out  1  operand offered downstream.
- operand_ready  in  1  downstream accepts operand.
- digit_cnt  out  $clog2(MAX_DIGITS+1)  digits entered so far.
- err  out  1  sticky: digit dropped (overflow) or illegal code (>9).

Behaviour:
- Reset values: operand=0, operand_valid=0, digit_cnt=0, err=0, state=IDLE, all key history registers=0.
- Press detection:
  - Each of key_any, key_clr and key_enter is registered once.
  - A press is a rising edge: current=1, previous=0.
  - key_digit is sampled in the cycle of the key_any rising edge.
  - Held keys never repeat.
- States:
  - IDLE: no digits entered. A digit press loads operand=digit, sets digit_cnt=1, goes to ENTRY.
  - ENTRY: a digit press with digit_cnt<MAX_DIGITS sets operand=operand*10+digit (computed as (op<<3)+(op<<1)+digit, VAL_W wide, no truncation by construction) and increments digit_cnt.
  - HOLD: operand_valid=1; operand and digit_cnt frozen.
- Overflow and illegal input:
  - A digit press with digit_cnt==MAX_DIGITS is ignored and sets err.
  - key_digit>9 on a press is ignored and sets err; value and count are unchanged.
- Enter:
  - Enter press in ENTRY goes to HOLD with operand_valid=1 on the next cycle.
  - Enter press in IDLE (zero digits) is ignored and produces no transfer.
- Handshake:
  - Transfer happens on the cycle where operand_valid && operand_ready.
  - The next cycle: operand=0, digit_cnt=0, operand_valid=0, state=IDLE.
  - operand is stable while operand_valid=1. Digit and enter presses in HOLD are ignored and do not set err.
- Clear:
  - A clear press in any state returns to IDLE with operand=0, digit_cnt=0, err=0, operand_valid=0.
  - Clear aborts a pending HOLD without transfer. Downstream must tolerate valid dropping only on clear.
- Simultaneous presses: priority is clr > enter > digit. A digit and enter pressed in the same cycle: enter acts on the pre-digit value and the digit is discarded.
- Latency:
  - Key edge to operand/digit_cnt update: 1 cycle after the registered edge, i.e. 2 clk from the input change.
  - Enter edge to operand_valid: same timing.
- Reset mid-operation: asynchronous return to reset values. Any in-flight operand is lost.

Optional Feature:
- Macro: DIGIT_ENTRY_DEBOUNCE_EN.
- When defined:
  - Each of key_any, key_clr and key_enter passes through a debouncer. The filtered level changes only after the raw input has been stable for DEBOUNCE_CYCLES consecutive cycles.
  - key_digit is captured when the filtered key_any rises.
  - Press latency grows by DEBOUNCE_CYCLES.
- When undefined: raw levels feed the edge detectors directly, and DEBOUNCE_CYCLES is unused.

Decomposition:
- Shared package calc_pkg holds:
  - the state enum (IDLE, ENTRY, HOLD);
  - localparam DIGIT_W=4;
  - localparam DIGIT_MAX=9.
- Natural sub-module: key_edge_det. It takes one key level and emits a one-cycle press pulse, and contains the debouncer under the macro. It is instantiated three times.

Test Plan:
- Press 1, 2, 3, then enter with ready=1 -> operand_valid for exactly 1 cycle with operand=123; then operand=0, digit_cnt=0, IDLE.
- Press 9, 9, 9, 9, 5 with MAX_DIGITS=4 -> operand=9999, digit_cnt=4, err=1; enter gives 9999. Clear then gives err=0.
- Enter with ready=0 -> operand_valid held and operand=42 stable for 10 cycles; digit presses during HOLD are ignored; ready=1 gives a single transfer.
- key_any held high for 20 cycles with key_digit=7 -> exactly one digit accepted, operand=7.
- key_clr and key_enter rising in the same cycle with 5 entered -> no operand_valid, operand=0, IDLE. Digit and enter in the same cycle with 12 entered -> transfer of 12.
- rst asserted mid-entry (operand=34) asynchronously between clock edges -> all outputs 0 immediately.
- With DIGIT_ENTRY_DEBOUNCE_EN defined, a 2-cycle glitch on key_any is rejected, and a stable press is accepted DEBOUNCE_CYCLES later.
